// File: rtl/seqdet_frame_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : seqdet_frame_ctrl
// Description : Frame-level controller for the serial sequence detector.
//               Takes parallel words over a valid/ready handshake, serialises
//               them MSB-first into a history register, compares the history
//               against a runtime-programmable pattern, pulses z on every
//               match and counts matches per frame. Signals end of frame.
// Optional    : SEQDET_OVERLAP_EN - when defined, history is kept after a
//               match (overlapping detection); otherwise it clears on a match.
// Ports       : clk          rising-edge clock
//               reset        synchronous, active-low
//               cfg_we       pattern/length write strobe
//               cfg_pattern  new pattern, LSB = most recent bit
//               cfg_len      new pattern length, 1..DATA_W
//               in_valid     word valid
//               in_data      word, shifted out MSB first
//               in_last      word is the last of its frame
//               in_ready     controller can take a word
//               z            registered match pulse
//               match_cnt    saturating match count for current/last frame
//               busy         frame in progress
//               done         one-cycle end-of-frame pulse
//               err          one-cycle rejected-config pulse
// Revision    : 1.0 - initial release
// ============================================================================
module seqdet_frame_ctrl #(
    parameter int                DATA_W      = 8,
    parameter int                CNT_W       = 16,
    parameter logic [DATA_W-1:0] DEF_PATTERN = DATA_W'(8'h0A),
    parameter int                DEF_LEN     = 4,
    localparam int               LEN_W       = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [DATA_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              z,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state_q,   w_state_d;
    logic [DATA_W-1:0]  r_sreg_q,    w_sreg_d;
    logic [BIT_W-1:0]   r_bitcnt_q,  w_bitcnt_d;
    logic               r_last_q,    w_last_d;
    logic               r_open_q,    w_open_d;
    logic [DATA_W-1:0]  r_hist_q,    w_hist_d;
    logic [LEN_W-1:0]   r_fill_q,    w_fill_d;
    logic [DATA_W-1:0]  r_pattern_q, w_pattern_d;
    logic [LEN_W-1:0]   r_len_q,     w_len_d;
    logic [CNT_W-1:0]   r_cnt_q,     w_cnt_d;
    logic               r_z_q,       w_z_d;
    logic               r_done_q,    w_done_d;
    logic               r_err_q,     w_err_d;

    logic               w_busy;
    logic               w_ready;
    logic               w_accept;
    logic [DATA_W-1:0]  w_mask;
    logic [DATA_W-1:0]  w_hist_nx;
    logic [LEN_W-1:0]   w_fill_nx;
    logic               w_match;

    assign w_busy   = (r_state_q != ST_IDLE) | r_open_q;
    assign w_ready  = (r_state_q == ST_IDLE) |
                      ((r_state_q == ST_SHIFT) & (r_bitcnt_q == '0));
    assign w_accept = in_valid & w_ready;

    // Selects the low len bits of history and pattern for comparison.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_mask[i] = (i < int'(r_len_q));
        end
    end

    // Candidate history after shifting the current MSB in; only used in SHIFT.
    assign w_hist_nx = {r_hist_q[DATA_W-2:0], r_sreg_q[DATA_W-1]};
    assign w_fill_nx = (r_fill_q < LEN_W'(DATA_W)) ? r_fill_q + 1'b1 : r_fill_q;
    assign w_match   = ((w_hist_nx & w_mask) == (r_pattern_q & w_mask)) &&
                       (w_fill_nx >= r_len_q);

    always_comb begin
        w_state_d   = r_state_q;
        w_sreg_d    = r_sreg_q;
        w_bitcnt_d  = r_bitcnt_q;
        w_last_d    = r_last_q;
        w_open_d    = r_open_q;
        w_hist_d    = r_hist_q;
        w_fill_d    = r_fill_q;
        w_pattern_d = r_pattern_q;
        w_len_d     = r_len_q;
        w_cnt_d     = r_cnt_q;
        w_z_d       = 1'b0;
        w_done_d    = 1'b0;
        w_err_d     = 1'b0;

        // Config is only legal between frames; an accepted write lands on the
        // same edge as a simultaneous word load, so that word sees it.
        if (cfg_we) begin
            if (!w_busy && (cfg_len != '0) && (cfg_len <= LEN_W'(DATA_W))) begin
                w_pattern_d = cfg_pattern;
                w_len_d     = cfg_len;
            end else begin
                w_err_d = 1'b1;
            end
        end

        case (r_state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    w_sreg_d   = in_data;
                    w_bitcnt_d = BIT_W'(DATA_W - 1);
                    w_last_d   = in_last;
                    w_open_d   = 1'b1;
                    w_state_d  = ST_SHIFT;
                    if (!r_open_q) begin
                        w_cnt_d = '0;
                    end
                end
            end

            ST_SHIFT: begin
                w_sreg_d   = r_sreg_q << 1;
                w_bitcnt_d = r_bitcnt_q - 1'b1;
                w_hist_d   = w_hist_nx;
                w_fill_d   = w_fill_nx;
                if (w_match) begin
                    w_z_d = 1'b1;
                    if (r_cnt_q != '1) begin
                        w_cnt_d = r_cnt_q + 1'b1;
                    end
`ifdef SEQDET_OVERLAP_EN
`else
                    w_hist_d = '0;
                    w_fill_d = '0;
`endif
                end
                if (r_bitcnt_q == '0) begin
                    if (w_accept) begin
                        // Reload on the last bit's edge: no bubble between words.
                        w_sreg_d   = in_data;
                        w_bitcnt_d = BIT_W'(DATA_W - 1);
                        w_last_d   = in_last;
                    end else if (r_last_q) begin
                        w_state_d = ST_DONE;
                        w_done_d  = 1'b1;
                    end else begin
                        w_state_d = ST_IDLE;
                    end
                end
            end

            ST_DONE: begin
                w_hist_d  = '0;
                w_fill_d  = '0;
                w_open_d  = 1'b0;
                w_state_d = ST_IDLE;
            end

            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state_q   <= ST_IDLE;
            r_sreg_q    <= '0;
            r_bitcnt_q  <= '0;
            r_last_q    <= 1'b0;
            r_open_q    <= 1'b0;
            r_hist_q    <= '0;
            r_fill_q    <= '0;
            r_pattern_q <= DEF_PATTERN;
            r_len_q     <= LEN_W'(DEF_LEN);
            r_cnt_q     <= '0;
            r_z_q       <= 1'b0;
            r_done_q    <= 1'b0;
            r_err_q     <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_sreg_q    <= w_sreg_d;
            r_bitcnt_q  <= w_bitcnt_d;
            r_last_q    <= w_last_d;
            r_open_q    <= w_open_d;
            r_hist_q    <= w_hist_d;
            r_fill_q    <= w_fill_d;
            r_pattern_q <= w_pattern_d;
            r_len_q     <= w_len_d;
            r_cnt_q     <= w_cnt_d;
            r_z_q       <= w_z_d;
            r_done_q    <= w_done_d;
            r_err_q     <= w_err_d;
        end
    end

    assign in_ready  = w_ready;
    assign z         = r_z_q;
    assign match_cnt = r_cnt_q;
    assign busy      = w_busy;
    assign done      = r_done_q;
    assign err       = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_seqdet_frame_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_seqdet_frame_ctrl
// Description : Directed testbench for seqdet_frame_ctrl. Stimulus pushes the
//               expected z/done/err events (cycle and count) into a queue; a
//               monitor pops and compares whenever the DUT raises one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seqdet_frame_ctrl;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;
    localparam int LEN_W  = 4;

    localparam int K_Z    = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cfg_we = 1'b0;
    logic [DATA_W-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]  cfg_len = '0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic              z;
    logic [CNT_W-1:0]  match_cnt;
    logic              busy;
    logic              done;
    logic              err;

    seqdet_frame_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .z           (z),
        .match_cnt   (match_cnt),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Number of rising edges so far; an event caused by edge N is seen at
    // the following falling edge while cyc == N.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int at;
        int cnt;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic expect_ev(input int kind, input int at, input int cnt);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic observe(input int kind);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d cycle=%0d actual=present required=absent", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.at != cyc || (kind != K_ERR && e.cnt != int'(match_cnt))) begin
                errors++;
                $display("FAIL event actual kind=%0d cycle=%0d cnt=%0d required kind=%0d cycle=%0d cnt=%0d",
                         kind, cyc, match_cnt, e.kind, e.at, e.cnt);
            end
        end
    endtask

    always @(negedge clk) begin
        if (z)    observe(K_Z);
        if (done) observe(K_DONE);
        if (err)  observe(K_ERR);
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int e;

        // ---- 1: reset ----
        repeat (2) @(negedge clk);
        check("rst_z",        32'(z), 0);
        check("rst_cnt",      32'(match_cnt), 0);
        check("rst_done",     32'(done), 0);
        check("rst_err",      32'(err), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_busy",     32'(busy), 0);
        reset = 1'b1;
        @(negedge clk);

        // ---- 2: default pattern 1010, word AA, last ----
        in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b1;
        e = cyc + 1;
        expect_ev(K_Z, e + 4, 1);
`ifdef SEQDET_OVERLAP_EN
        expect_ev(K_Z, e + 6, 2);
        expect_ev(K_Z, e + 8, 3);
        expect_ev(K_DONE, e + 8, 3);
`else
        expect_ev(K_Z, e + 8, 2);
        expect_ev(K_DONE, e + 8, 2);
`endif
        @(negedge clk);
        in_valid = 1'b0;
        check("t2_ready_in_shift", 32'(in_ready), 0);
        check("t2_busy_in_shift",  32'(busy), 1);
        wait_until(e + 9);
        check("t2_busy_after",  32'(busy), 0);
        check("t2_ready_after", 32'(in_ready), 1);
`ifdef SEQDET_OVERLAP_EN
        check("t2_cnt_hold", 32'(match_cnt), 3);
`else
        check("t2_cnt_hold", 32'(match_cnt), 2);
`endif

        // ---- 3: back-to-back A5 then 0A ----
        in_valid = 1'b1; in_data = 8'hA5; in_last = 1'b0;
        e = cyc + 1;
        expect_ev(K_Z, e + 4, 1);
        expect_ev(K_Z, e + 9, 2);
        expect_ev(K_Z, e + 16, 3);
        expect_ev(K_DONE, e + 16, 3);
        wait_until(e + 7);
        check("t3_no_bubble", 32'(in_ready), 1);
        in_data = 8'h0A; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("t3_ready_after_reload", 32'(in_ready), 0);
        wait_until(e + 17);
        check("t3_cnt", 32'(match_cnt), 3);

        // ---- 4: config while busy is rejected, pattern stays 1010 ----
        in_valid = 1'b1; in_data = 8'h0A; in_last = 1'b1;
        e = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_until(e + 2);
        cfg_we = 1'b1; cfg_pattern = 8'h07; cfg_len = 4'd3;
        expect_ev(K_ERR, e + 3, 0);
        expect_ev(K_Z, e + 8, 1);
        expect_ev(K_DONE, e + 8, 1);
        @(negedge clk);
        cfg_we = 1'b0;
        wait_until(e + 9);

        // zero length in IDLE is rejected
        cfg_we = 1'b1; cfg_pattern = 8'h07; cfg_len = 4'd0;
        expect_ev(K_ERR, cyc + 1, 0);
        @(negedge clk);
        cfg_we = 1'b0;
        @(negedge clk);

        // ---- 5: cfg 111/len 3 together with word FF; word uses new pattern ----
        cfg_we = 1'b1; cfg_pattern = 8'h07; cfg_len = 4'd3;
        in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
        e = cyc + 1;
`ifdef SEQDET_OVERLAP_EN
        for (int k = 3; k <= 8; k++) expect_ev(K_Z, e + k, k - 2);
        expect_ev(K_DONE, e + 8, 6);
`else
        expect_ev(K_Z, e + 3, 1);
        expect_ev(K_Z, e + 6, 2);
        expect_ev(K_DONE, e + 8, 2);
`endif
        @(negedge clk);
        cfg_we = 1'b0; in_valid = 1'b0;
        check("t5_cfg_no_err", 32'(err), 0);
        wait_until(e + 9);
`ifdef SEQDET_OVERLAP_EN
        check("t5_cnt", 32'(match_cnt), 6);
`else
        check("t5_cnt", 32'(match_cnt), 2);
`endif

        // ---- 6: reset in the 3rd SHIFT cycle abandons the frame ----
        in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
        e = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_until(e + 2);
        reset = 1'b0;
        @(negedge clk);
        check("t6_ready", 32'(in_ready), 1);
        check("t6_busy",  32'(busy), 0);
        check("t6_z",     32'(z), 0);
        check("t6_cnt",   32'(match_cnt), 0);
        check("t6_done",  32'(done), 0);
        reset = 1'b1;
        repeat (12) @(negedge clk);

        // default pattern 1010 restored by reset
        in_valid = 1'b1; in_data = 8'h0A; in_last = 1'b1;
        e = cyc + 1;
        expect_ev(K_Z, e + 8, 1);
        expect_ev(K_DONE, e + 8, 1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_until(e + 11);

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
